hex_display_driver: RTL

Downstream display stage of the stopwatch. Consumes the four BCD digits from the time counter plus the FSM's counting flag and drives the four active-low 7-segment outputs HEX0..HEX3. On each refresh tick it captures a coherent snapshot of all digits, then decodes them one digit per clock through a single shared decoder into registered outputs. When paused it blinks the display. It replaces the constant-blank HEX assignments in the top level.

---
 rtl/hex_display_driver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hex_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_driver
// Purpose  : Display stage of the stopwatch. When refresh_tick arrives with the
//            sequencer idle, all four BCD digits are captured in one snapshot.
//            They are then decoded one digit per clock through a single shared
//            7-segment decoder into registered active-low outputs. While the
//            stopwatch is paused, the display blinks: a blink phase toggles
//            every BLINK_TICKS refresh ticks, and digits written during the
//            OFF phase are blanked.
//
// Ports    : clk          - display-domain clock
//            rst_n        - asynchronous active-low reset
//            refresh_tick - single-cycle enable that starts a display update
//            sec_ones     - BCD seconds ones   -> hex0
//            sec_tens     - BCD seconds tens   -> hex1
//            min_ones     - BCD minutes ones   -> hex2
//            min_tens     - BCD minutes tens   -> hex3
//            counting     - 1 = running (no blink), 0 = paused/stopped
//            hex0..hex3   - active-low segments, bit6..bit0 = g..a
//            frame_done   - one-cycle pulse in the cycle hex3 is written
//
// Options  : LEADING_ZERO_BLANK_EN - when defined, a zero minutes-tens digit is
//            blanked. A zero minutes-ones digit is also blanked when the
//            minutes-tens digit is zero. Blink blanking still takes priority.
//
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_driver #(
    parameter int         BLINK_TICKS   = 500,
    parameter logic [6:0] BLANK_PATTERN = 7'b1111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_tick,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic       counting,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       frame_done
);

    localparam logic [15:0] c_blink_last = 16'(BLINK_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D0   = 3'd1,
        S_D1   = 3'd2,
        S_D2   = 3'd3,
        S_D3   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Digit snapshot. The run flag is not captured because blanking samples
    // the live blink phase at write time, so a captured copy would have no
    // reader.
    logic [3:0]  r_snap_sec_ones;
    logic [3:0]  r_snap_sec_tens;
    logic [3:0]  r_snap_min_ones;
    logic [3:0]  r_snap_min_tens;

    logic [15:0] r_blink_cnt;
    logic        r_phase_on;

    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic [6:0]  r_hex3;

    logic        w_start;
    logic [3:0]  w_sel_digit;
    logic [6:0]  w_seg;
    logic        w_lead_blank;
    logic [6:0]  w_write_val;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;  // non-BCD: dash (segment g only)
        endcase
        return seg;
    endfunction

    // A tick is accepted only when idle. Ticks during D0..D3 are dropped.
    assign w_start = (r_state == S_IDLE) && refresh_tick;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_start ? S_D0 : S_IDLE;
            S_D0:    w_next_state = S_D1;
            S_D1:    w_next_state = S_D2;
            S_D2:    w_next_state = S_D3;
            S_D3:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Snapshot capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_sec_ones <= 4'd0;
            r_snap_sec_tens <= 4'd0;
            r_snap_min_ones <= 4'd0;
            r_snap_min_tens <= 4'd0;
        end else if (w_start) begin
            r_snap_sec_ones <= sec_ones;
            r_snap_sec_tens <= sec_tens;
            r_snap_min_ones <= min_ones;
            r_snap_min_tens <= min_tens;
        end
    end

    // ------------------------------------------------------------------------
    // Blink timing. Every refresh tick counts while paused, including ticks
    // the sequencer drops. Running forces the phase ON, so a running
    // display is never blanked.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= 16'd0;
            r_phase_on  <= 1'b1;
        end else if (counting) begin
            r_blink_cnt <= 16'd0;
            r_phase_on  <= 1'b1;
        end else if (refresh_tick) begin
            if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt <= 16'd0;
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shared decode path
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_digit = r_snap_sec_ones;
        case (r_state)
            S_D0:    w_sel_digit = r_snap_sec_ones;
            S_D1:    w_sel_digit = r_snap_sec_tens;
            S_D2:    w_sel_digit = r_snap_min_ones;
            S_D3:    w_sel_digit = r_snap_min_tens;
            default: w_sel_digit = r_snap_sec_ones;
        endcase
    end

    assign w_seg = seg_decode(w_sel_digit);

`ifdef LEADING_ZERO_BLANK_EN
    // Only the minutes digits are suppressed. Minutes-ones is suppressed only
    // when minutes-tens is also zero, so 10:xx keeps its zero.
    assign w_lead_blank = ((r_state == S_D3) && (r_snap_min_tens == 4'd0)) ||
                          ((r_state == S_D2) && (r_snap_min_tens == 4'd0) &&
                           (r_snap_min_ones == 4'd0));
`else
    assign w_lead_blank = 1'b0;
`endif

    assign w_write_val = (!r_phase_on || w_lead_blank) ? BLANK_PATTERN : w_seg;

    // ------------------------------------------------------------------------
    // Output registers: each D state writes exactly one digit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex0 <= BLANK_PATTERN;
            r_hex1 <= BLANK_PATTERN;
            r_hex2 <= BLANK_PATTERN;
            r_hex3 <= BLANK_PATTERN;
        end else begin
            if (r_state == S_D0) r_hex0 <= w_write_val;
            if (r_state == S_D1) r_hex1 <= w_write_val;
            if (r_state == S_D2) r_hex2 <= w_write_val;
            if (r_state == S_D3) r_hex3 <= w_write_val;
        end
    end

    assign hex0       = r_hex0;
    assign hex1       = r_hex1;
    assign hex2       = r_hex2;
    assign hex3       = r_hex3;
    assign frame_done = (r_state == S_D3);

endmodule
`default_nettype wire
